// File: rtl/video_sequencer.sv
`default_nettype none
// ============================================================================
// video_sequencer: phase sequencer that issues registered video fetch strobes
// and grants host (ISA) access windows between fetch groups.
// Revision: 1.0
// ============================================================================
module video_sequencer #(
    parameter int SEQ_BITS    = 5,
    parameter int FETCH_SLOTS = 2,
    parameter int ISA_LEN     = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          mode,
    input  logic                isa_req,
    output logic [SEQ_BITS-1:0] clk_seq,
    output logic [1:0]          mode_active,
    output logic                lclk,
    output logic                hclk,
    output logic                crtc_clk,
    output logic                vram_read,
    output logic                vram_read_a0,
    output logic                vram_read_char,
    output logic                vram_read_att,
    output logic                charrom_read,
    output logic                disp_pipeline,
    output logic                isa_op_enable,
    output logic                isa_ack,
    output logic                isa_busy
);

    localparam int P        = 1 << SEQ_BITS;
    localparam int H        = P / FETCH_SLOTS;
    localparam int HB       = $clog2(H);
    localparam int ISA_LAST = H - 1 - ISA_LEN;
    localparam int CW       = $clog2(ISA_LEN + 1);

    localparam logic [SEQ_BITS-1:0] SEQ_ONE     = SEQ_BITS'(1);
    localparam logic [SEQ_BITS-1:0] SEQ_MAX     = SEQ_BITS'(P - 1);
    localparam logic [SEQ_BITS-1:0] OFF_MASK    = SEQ_BITS'(H - 1);
    localparam logic [SEQ_BITS-1:0] GRP_MASK_LO = SEQ_BITS'(FETCH_SLOTS - 1);
    localparam logic [SEQ_BITS-1:0] GRP_MASK_HI = SEQ_BITS'(((FETCH_SLOTS >= 2) ? FETCH_SLOTS / 2 : 1) - 1);
    localparam logic [SEQ_BITS-1:0] GRP_MASK_QD = SEQ_BITS'(((FETCH_SLOTS >= 4) ? FETCH_SLOTS / 4 : 1) - 1);
    localparam logic [CW-1:0]       BUSY_LEN    = CW'(ISA_LEN);
    localparam logic [CW-1:0]       BUSY_ONE    = CW'(1);

    localparam logic [1:0] MODE_LOW   = 2'd0;
    localparam logic [1:0] MODE_HIGH  = 2'd1;
    localparam logic [1:0] MODE_BLANK = 2'd3;

    logic [SEQ_BITS-1:0] clk_seq_q, seq_d, off_d, grp_d, grp_mask;
    logic [1:0]          mode_active_q, mode_d;
    logic [CW-1:0]       busy_cnt_q, busy_cnt_d;
    logic                blank_d, active_d, grant_d;
    int                  off_i, isa_lo;

    logic lclk_q, hclk_q, crtc_q, vram_q, a0_q, char_q, att_q, crom_q, disp_q, isa_en_q, ack_q;
    logic lclk_d, hclk_d, crtc_d, vram_d, a0_d, char_d, att_d, crom_d, disp_d, isa_en_d;

    // Everything is decoded from the next phase so each strobe lands in the
    // same cycle as the clk_seq value it belongs to.
    always_comb begin
        seq_d    = clk_seq_q + SEQ_ONE;
        mode_d   = (clk_seq_q == SEQ_MAX) ? mode : mode_active_q;
        off_d    = seq_d & OFF_MASK;
        grp_d    = seq_d >> HB;
        blank_d  = (mode_d == MODE_BLANK);
        case (mode_d)
            MODE_LOW:  grp_mask = GRP_MASK_LO;
            MODE_HIGH: grp_mask = GRP_MASK_HI;
            default:   grp_mask = GRP_MASK_QD;
        endcase
        active_d = !blank_d && ((grp_d & grp_mask) == '0);
        off_i    = int'(off_d);
        isa_lo   = blank_d ? 0 : 5;

        lclk_d   = (seq_d == '0);
        hclk_d   = (off_i == 0);
        vram_d   = !blank_d && (off_i >= 1) && (off_i <= 3);
        a0_d     = !blank_d && (off_i == 2);
        crtc_d   = active_d && (off_i == 0);
        char_d   = active_d && (off_i == 2);
        att_d    = active_d && (off_i == 3);
        crom_d   = active_d && (off_i == 3);
        disp_d   = active_d && (off_i == 4);
        isa_en_d = (off_i >= isa_lo) && (off_i <= H - 2);

        // A grant may start right after the last busy cycle; the start window
        // keeps the whole operation clear of the next fetch group.
        grant_d  = isa_req && (busy_cnt_q <= BUSY_ONE) &&
                   (off_i >= isa_lo) && (off_i <= ISA_LAST);
        if (grant_d) begin
            busy_cnt_d = BUSY_LEN;
        end else if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - BUSY_ONE;
        end else begin
            busy_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_seq_q     <= '0;
            mode_active_q <= '0;
            busy_cnt_q    <= '0;
            lclk_q        <= 1'b0;
            hclk_q        <= 1'b0;
            crtc_q        <= 1'b0;
            vram_q        <= 1'b0;
            a0_q          <= 1'b0;
            char_q        <= 1'b0;
            att_q         <= 1'b0;
            crom_q        <= 1'b0;
            disp_q        <= 1'b0;
            isa_en_q      <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            clk_seq_q     <= seq_d;
            mode_active_q <= mode_d;
            busy_cnt_q    <= busy_cnt_d;
            lclk_q        <= lclk_d;
            hclk_q        <= hclk_d;
            crtc_q        <= crtc_d;
            vram_q        <= vram_d;
            a0_q          <= a0_d;
            char_q        <= char_d;
            att_q         <= att_d;
            crom_q        <= crom_d;
            disp_q        <= disp_d;
            isa_en_q      <= isa_en_d;
            ack_q         <= grant_d;
        end
    end

    assign clk_seq        = clk_seq_q;
    assign mode_active    = mode_active_q;
    assign lclk           = lclk_q;
    assign hclk           = hclk_q;
    assign crtc_clk       = crtc_q;
    assign vram_read      = vram_q;
    assign vram_read_a0   = a0_q;
    assign vram_read_char = char_q;
    assign vram_read_att  = att_q;
    assign charrom_read   = crom_q;
    assign disp_pipeline  = disp_q;
    assign isa_op_enable  = isa_en_q;
    assign isa_ack        = ack_q;
    assign isa_busy       = (busy_cnt_q != '0);

endmodule
`default_nettype wire
